// File: rtl/gate_seq_pkg.sv
// rtl/gate_seq_pkg.sv - shared opcodes, FSM states and parameter limits for the gate sequencer
package gate_seq_pkg;

    typedef enum logic [2:0] {
        OP_NOT  = 3'd0,
        OP_AND  = 3'd1,
        OP_OR   = 3'd2,
        OP_XOR  = 3'd3,
        OP_NAND = 3'd4,
        OP_NOR  = 3'd5,
        OP_XNOR = 3'd6,
        OP_BUF  = 3'd7
    } gate_op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } seq_state_e;

    localparam int N_IN_MIN   = 1;
    localparam int N_IN_MAX   = 4;
    localparam int SETTLE_MIN = 1;
    localparam int SETTLE_MAX = 15;

endpackage

// File: rtl/gate_ref_model.sv
// rtl/gate_ref_model.sv - combinational expected output of the selected gate for a stimulus vector
module gate_ref_model
    import gate_seq_pkg::*;
#(
    parameter int N_IN = 2
) (
    input  logic [2:0]      gate_sel,
    input  logic [N_IN-1:0] vec,
    output logic            exp_y
);

    always_comb begin
        exp_y = 1'b0;
        case (gate_op_e'(gate_sel))
            OP_NOT:  exp_y = ~vec[0];
            OP_AND:  exp_y = &vec;
            OP_OR:   exp_y = |vec;
            OP_XOR:  exp_y = ^vec;
            OP_NAND: exp_y = ~&vec;
            OP_NOR:  exp_y = ~|vec;
            OP_XNOR: exp_y = ~^vec;
            OP_BUF:  exp_y = vec[0];
            default: exp_y = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_tt_sequencer.sv
// rtl/gate_tt_sequencer.sv - truth-table sweep of a gate under test; GATE_SEQ_FAIL_LOG_EN adds first_fail_vec
module gate_tt_sequencer
    import gate_seq_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      gate_sel,
    output logic [N_IN-1:0] vec,
    input  logic            dut_y,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt
`ifdef GATE_SEQ_FAIL_LOG_EN
    ,
    output logic [N_IN-1:0] first_fail_vec
`endif
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    seq_state_e state, state_nxt;
    logic [2:0] sel_q;
    logic [3:0] settle_cnt;
    logic       dut_y_q;
    logic       exp_y;
    logic       mismatch;

    gate_ref_model #(.N_IN(N_IN)) u_ref (
        .gate_sel (sel_q),
        .vec      (vec),
        .exp_y    (exp_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_APPLY;
            ST_APPLY:  begin busy = 1'b1; state_nxt = ST_SETTLE; end
            ST_SETTLE: begin
                busy = 1'b1;
                if (settle_cnt == SETTLE_LAST) state_nxt = ST_CHECK;
            end
            ST_CHECK:  begin
                busy      = 1'b1;
                state_nxt = (&vec) ? ST_DONE : ST_APPLY;
            end
            ST_DONE:   begin done = 1'b1; state_nxt = ST_IDLE; end
            default:   state_nxt = ST_IDLE;
        endcase
    end

    assign mismatch = (state == ST_CHECK) && (dut_y_q != exp_y);

    // dut_y is registered every cycle so CHECK sees the value after the full settle window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q          <= '0;
            vec            <= '0;
            err_cnt        <= '0;
            pass           <= 1'b0;
            settle_cnt     <= '0;
            dut_y_q        <= 1'b0;
`ifdef GATE_SEQ_FAIL_LOG_EN
            first_fail_vec <= '0;
`endif
        end else begin
            dut_y_q <= dut_y;
            case (state)
                ST_IDLE: if (start) begin
                    sel_q          <= gate_sel;
                    vec            <= '0;
                    err_cnt        <= '0;
                    pass           <= 1'b0;
`ifdef GATE_SEQ_FAIL_LOG_EN
                    first_fail_vec <= '0;
`endif
                end
                ST_APPLY:  settle_cnt <= '0;
                ST_SETTLE: settle_cnt <= settle_cnt + 4'd1;
                ST_CHECK: begin
                    if (mismatch) begin
                        err_cnt <= err_cnt + (N_IN+1)'(1);
`ifdef GATE_SEQ_FAIL_LOG_EN
                        if (err_cnt == '0) first_fail_vec <= vec;
`endif
                    end
                    if (!(&vec)) vec <= vec + N_IN'(1);
                end
                ST_DONE:   pass <= (err_cnt == '0);
                default: ;
            endcase
        end
    end

endmodule

// File: doc/gate_tt_sequencer.md
GATE_TT_SEQUENCER -- requirements
Module: gate_tt_sequencer

Interface
REQ-001 The block SHALL have parameter N_IN, default 2, legal range 1..4: number of gate inputs exercised.
REQ-002 The block SHALL have parameter SETTLE, default 2, legal range 1..15: number of wait cycles between applying a vector and sampling the result.
REQ-003 The block SHALL have a single clock, clk, with one clock domain; reset rst_n SHALL be asynchronous and active-low.
REQ-004 Ports SHALL be:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a truth-table sweep
- gate_sel  in  3  expected-function select
- vec  out  N_IN  stimulus driven to the gate under test
- dut_y  in  1  output of the gate under test
- busy  out  1  sweep in progress
- done  out  1  one-cycle completion pulse
- pass  out  1  last sweep had zero mismatches
- err_cnt  out  N_IN+1  mismatch count of last sweep
- first_fail_vec  out  N_IN  first mismatching vector (present only with the REQ-018 macro)

Function
REQ-005 gate_sel encoding SHALL be: 0 NOT, 1 AND, 2 OR, 3 XOR, 4 NAND, 5 NOR, 6 XNOR, 7 BUF.
- NOT and BUF use vec[0] only.
- All other functions reduce over all N_IN bits.
REQ-006 The FSM SHALL have states IDLE, APPLY, SETTLE, CHECK and DONE.
REQ-007 In IDLE, start=1 at a clock edge SHALL latch gate_sel, clear vec and err_cnt, and enter APPLY.
REQ-008 APPLY SHALL last one cycle, then enter SETTLE.
REQ-009 SETTLE SHALL last exactly SETTLE cycles, then enter CHECK.
REQ-010 CHECK SHALL last one cycle:
- compare the registered dut_y with the expected value for vec;
- on mismatch, increment err_cnt;
- if vec is all-ones, enter DONE;
- otherwise increment vec and enter APPLY.
REQ-011 DONE SHALL last one cycle, assert done, update pass to (err_cnt==0), then return to IDLE.
REQ-012 busy SHALL be 1 in APPLY, SETTLE and CHECK, and 0 in IDLE and DONE.
REQ-013 Latency: done SHALL be high in cycle 2^N_IN*(SETTLE+2)+1, counting the start-sampling edge as the end of cycle 0.
REQ-014 start SHALL be ignored outside IDLE, including during DONE; gate_sel changes after latch SHALL be ignored.
REQ-015 err_cnt SHALL NOT wrap or saturate; its width holds the maximum of 2^N_IN.
REQ-016 pass, err_cnt and first_fail_vec SHALL hold their values until the next accepted start.

Reset
REQ-017 When rst_n=0, at any time including mid-sweep, the block SHALL immediately force:
- state = IDLE
- vec = 0, busy = 0, done = 0
- pass = 0, err_cnt = 0, first_fail_vec = 0
- the latched gate_sel = 0

Configuration
REQ-018 With GATE_SEQ_FAIL_LOG_EN defined:
- port first_fail_vec SHALL exist;
- it SHALL be cleared on accepted start;
- it SHALL capture vec at the first mismatching CHECK of the sweep.
Without GATE_SEQ_FAIL_LOG_EN, the port and its register SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-019 A shared package gate_seq_pkg SHALL hold:
- the gate_sel opcode enumeration;
- the FSM state enumeration;
- N_IN and SETTLE range limits.
REQ-020 Expected-value computation SHALL be a combinational sub-module, gate_ref_model (inputs gate_sel and vec, output exp_y), which the sequencer instantiates once.

Verification
REQ-021 Scenario: N_IN=1, SETTLE=2, gate_sel=0, bench model dut_y=!vec[0] -> done in cycle 9, pass=1, err_cnt=0.
REQ-022 Scenario: N_IN=2, gate_sel=1 (AND), DUT wired as OR -> err_cnt=2, pass=0, first_fail_vec=2'b01.
REQ-023 Scenario: N_IN=4, gate_sel=4 (NAND), dut_y stuck at 1 -> err_cnt=1, first_fail_vec=4'hF.
REQ-024 Scenario: N_IN=2, start re-pulsed and gate_sel changed to 2 mid-sweep of a correct XOR DUT -> both ignored, single done, pass=1.
REQ-025 Scenario: rst_n pulsed low during SETTLE of the second vector -> all outputs zero immediately; a following start completes a clean sweep with correct counts.
